overheat_alarm: RTL

//   Downstream of the four-sensor temperature averager/comparator. Consumes its
//   per-sample too-hot verdict and debounces it into a latched, acknowledged

---
 rtl/overheat_alarm.sv | 121 ++++++++++++
 1 files changed

// File: rtl/overheat_alarm.sv
// rtl/overheat_alarm.sv - debounced, latched overheat alarm with hysteresis and saturating trip counter
// Moore FSM; alarm/fan_on are decoded straight from the state register.
module overheat_alarm #(
    parameter int TRIP_COUNT  = 4,
    parameter int CLEAR_COUNT = 8,
    parameter int CNT_W       = 4,
    parameter int TRIP_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic              too_hot,
    input  logic              alarm_ack,
    output logic [1:0]        state,
    output logic              alarm,
    output logic              fan_on,
    output logic [TRIP_W-1:0] trips
);

    typedef enum logic [1:0] {
        S_COOL    = 2'b00,
        S_WARMING = 2'b01,
        S_ALARM   = 2'b10,
        S_COOLING = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] TRIP_C  = CNT_W'(TRIP_COUNT);
    localparam logic [CNT_W-1:0] CLEAR_C = CNT_W'(CLEAR_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TRIP_W-1:0]  trips_q, trips_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [TRIP_W-1:0]  trips_inc;
    logic               hot, cool;

    assign hot       = sample_valid & too_hot;
    assign cool      = sample_valid & ~too_hot;
    assign cnt_inc   = cnt_q + CNT_ONE;
    assign trips_inc = (trips_q == {TRIP_W{1'b1}}) ? trips_q
                                                    : trips_q + {{(TRIP_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_COOL;
            cnt_q   <= '0;
            trips_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trips_q <= trips_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trips_d = trips_q;
        unique case (state_q)
            S_COOL: begin
                if (hot) begin
                    if (TRIP_C == CNT_ONE) begin
                        state_d = S_ALARM;
                        cnt_d   = '0;
                        trips_d = trips_inc;
                    end else begin
                        state_d = S_WARMING;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            S_WARMING: begin
                if (hot) begin
                    if (cnt_inc == TRIP_C) begin
                        state_d = S_ALARM;
                        cnt_d   = '0;
                        trips_d = trips_inc;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (cool) begin
                    state_d = S_COOL;
                    cnt_d   = '0;
                end
            end
            S_ALARM: begin
                // The clear count restarts on any hot sample, so only an unbroken cool run leaves ALARM.
                if (cool) begin
                    if (cnt_inc == CLEAR_C) begin
                        state_d = S_COOLING;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (hot) begin
                    cnt_d = '0;
                end
            end
            S_COOLING: begin
                if (hot) begin
                    state_d = S_ALARM;
                    cnt_d   = '0;
                end else if (alarm_ack) begin
                    state_d = S_COOL;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_COOL;
                cnt_d   = '0;
            end
        endcase
    end

    assign state  = state_q;
    assign alarm  = state_q[1];
    assign fan_on = (state_q != S_COOL);
    assign trips  = trips_q;

endmodule
